// File: rtl/render_pkg.sv
// Shared render-queue definitions: command layout, reader FSM states, screen defaults.
// Used by render_cmd_reader and by the HPS-side command writer so both agree on
// the 48-bit command format and the clip/transparency constants.
package render_pkg;

  localparam int CMD_W      = 48;
  localparam int MEM_ADDR_W = 9;   // 512-word image memory
  localparam int RGB_W      = 24;
  localparam int COORD_W    = 10;
  localparam int DIM_W      = 4;   // sprite dimensions stored as size-1, 1..16

  localparam int                SCREEN_W_DEF        = 640;
  localparam int                SCREEN_H_DEF        = 480;
  localparam logic [RGB_W-1:0]  TRANSPARENT_RGB_DEF = 24'hFF00FF;

  // Field order matches the queue word, MSB first: [47:38] x0 ... [9:0] reserved.
  typedef struct packed {
    logic [COORD_W-1:0]    x0;
    logic [COORD_W-1:0]    y0;
    logic [MEM_ADDR_W-1:0] base;
    logic [DIM_W-1:0]      w_m1;
    logic [DIM_W-1:0]      h_m1;
    logic                  eof;
    logic [9:0]            rsvd;
  } render_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT,
    ST_NEXT
  } rd_state_t;

  // Screen coordinate of a sprite pixel, one bit wider so off-screen sums never wrap.
  function automatic logic [COORD_W:0] coord_sum(input logic [COORD_W-1:0] origin,
                                                 input logic [DIM_W-1:0]   offset);
    return {1'b0, origin} + {{(COORD_W+1-DIM_W){1'b0}}, offset};
  endfunction

endpackage

// File: rtl/render_cmd_reader_if.sv
// Bus bundle around render_cmd_reader: render queue (show-ahead, pop strobe),
// image memory read port (1-cycle sync read) and pixel output (valid/ready).
// master = the reader, slave = queue/memory/pixel-writer side.
interface render_cmd_reader_if;
  import render_pkg::*;

  logic                  q_empty;
  logic [CMD_W-1:0]      q_dout;
  logic                  q_pop_front;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [RGB_W-1:0]      mem_dout;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [COORD_W-1:0]    pix_x;
  logic [COORD_W-1:0]    pix_y;
  logic [RGB_W-1:0]      pix_rgb;

  modport master (
    input  q_empty, q_dout, mem_dout, pix_ready,
    output q_pop_front, mem_addr, pix_valid, pix_x, pix_y, pix_rgb
  );

  modport slave (
    output q_empty, q_dout, mem_dout, pix_ready,
    input  q_pop_front, mem_addr, pix_valid, pix_x, pix_y, pix_rgb
  );

endinterface

// File: rtl/sprite_walker.sv
// Sprite scan counters: column/row position and image address, with last-pixel detect.
// Latency: load/step take effect on the next clk50 edge; last_o is combinational.
// Backpressure: none of its own, it only advances when the FSM pulses step_i.
// Ports: load_i restarts at base_i (col=row=0); step_i advances one pixel in raster order.
module sprite_walker
  import render_pkg::*;
(
  input  logic                  clk50,
  input  logic                  reset_reg,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [MEM_ADDR_W-1:0] base_i,
  input  logic [DIM_W-1:0]      w_m1_i,
  input  logic [DIM_W-1:0]      h_m1_i,
  output logic [MEM_ADDR_W-1:0] addr_o,
  output logic [DIM_W-1:0]      col_o,
  output logic [DIM_W-1:0]      row_o,
  output logic                  last_o
);

  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [DIM_W-1:0]      col_q, col_d;
  logic [DIM_W-1:0]      row_q, row_d;

  always_ff @(posedge clk50 or posedge reset_reg) begin
    if (reset_reg) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  always_comb begin
    addr_d = addr_q;
    col_d  = col_q;
    row_d  = row_q;
    if (load_i) begin
      addr_d = base_i;
      col_d  = '0;
      row_d  = '0;
    end else if (step_i) begin
      // Image is stored row-major and contiguous, so the address simply counts;
      // it wraps 511 -> 0 so a sprite may straddle the end of memory.
      addr_d = addr_q + 1'b1;
      if (col_q == w_m1_i) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign addr_o = addr_q;
  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == w_m1_i) && (row_q == h_m1_i);

endmodule

// File: rtl/render_cmd_reader.sv
// Render queue consumer: pops a sprite command, reads its pixels, emits visible ones.
// Latency: 4 clk50 per emitted pixel (FETCH, WAIT, EMIT, NEXT), 3 per skipped pixel.
// Backpressure: holds pixel stable in EMIT until pix_ready; queue only popped when idle.
// Ports: clk50/reset_reg (async, active-high); enable gates new pops; io = queue,
// image memory and pixel bus; frame_done pulses after an eof command; busy = not IDLE.
module render_cmd_reader
  import render_pkg::*;
#(
  parameter int               SCREEN_W        = SCREEN_W_DEF,
  parameter int               SCREEN_H        = SCREEN_H_DEF,
  parameter logic [RGB_W-1:0] TRANSPARENT_RGB = TRANSPARENT_RGB_DEF
) (
  input  logic                clk50,
  input  logic                reset_reg,
  input  logic                enable,
  render_cmd_reader_if.master io,
  output logic                frame_done,
  output logic                busy
);

  rd_state_t          state_q, state_d;
  render_cmd_t        cmd_q, cmd_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d;
  logic [COORD_W-1:0] pix_y_q, pix_y_d;
  logic [RGB_W-1:0]   pix_rgb_q, pix_rgb_d;
  logic               frame_done_q, frame_done_d;

  logic               pop;
  logic               walk_load;
  logic               walk_step;
  logic [DIM_W-1:0]   col;
  logic [DIM_W-1:0]   row;
  logic               last;
  logic [COORD_W:0]   sum_x;
  logic [COORD_W:0]   sum_y;
  logic               skip_pix;
  logic               unused_rsvd;

  sprite_walker u_walker (
    .clk50     (clk50),
    .reset_reg (reset_reg),
    .load_i    (walk_load),
    .step_i    (walk_step),
    .base_i    (cmd_q.base),
    .w_m1_i    (cmd_q.w_m1),
    .h_m1_i    (cmd_q.h_m1),
    .addr_o    (io.mem_addr),
    .col_o     (col),
    .row_o     (row),
    .last_o    (last)
  );

  assign sum_x    = coord_sum(cmd_q.x0, col);
  assign sum_y    = coord_sum(cmd_q.y0, row);
  assign skip_pix = (sum_x >= (COORD_W+1)'(SCREEN_W)) ||
                    (sum_y >= (COORD_W+1)'(SCREEN_H)) ||
                    (io.mem_dout == TRANSPARENT_RGB);

  always_ff @(posedge clk50 or posedge reset_reg) begin
    if (reset_reg) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    walk_load    = 1'b0;
    walk_step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Holding off while frame_done is high keeps the pulse and the next pop
        // in separate cycles.
        if (enable && !io.q_empty && !frame_done_q) begin
          pop     = 1'b1;
          cmd_d   = io.q_dout;
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        walk_load = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        pix_rgb_d = io.mem_dout;
        pix_x_d   = sum_x[COORD_W-1:0];
        pix_y_d   = sum_y[COORD_W-1:0];
        state_d   = skip_pix ? ST_NEXT : ST_EMIT;
      end
      ST_EMIT: begin
        if (io.pix_ready) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        walk_step = 1'b1;
        if (last) begin
          frame_done_d = cmd_q.eof;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The pop is decoded from IDLE, which is also the reset state, so it is
  // masked while reset is asserted.
  assign io.q_pop_front = pop && !reset_reg;
  assign io.pix_valid   = (state_q == ST_EMIT);
  assign io.pix_x       = pix_x_q;
  assign io.pix_y       = pix_y_q;
  assign io.pix_rgb     = pix_rgb_q;
  assign frame_done     = frame_done_q;
  assign busy           = (state_q != ST_IDLE);

  assign unused_rsvd = ^cmd_q.rsvd;

endmodule

// File: tb/tb_render_cmd_reader.sv
module tb_render_cmd_reader;

  logic clk50 = 1'b0;
  logic reset_reg;
  logic enable;
  logic frame_done;
  logic busy;

  render_cmd_reader_if bus();

  render_cmd_reader dut (
    .clk50      (clk50),
    .reset_reg  (reset_reg),
    .enable     (enable),
    .io         (bus),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial forever #10 clk50 = ~clk50;

  logic [23:0] mem [512];
  logic [47:0] cmdq [$];
  logic [43:0] got [$];
  logic [43:0] exp_px [$];
  int pop_cyc [$];
  int fd_cyc [$];
  int addr_log [$];
  int cyc = 0;
  int valid_cycles = 0;
  int act_cycles = 0;
  int checks = 0;
  int errors = 0;
  bit pop_seen = 1'b0;
  bit busy_prev = 1'b0;

  // Image memory: synchronous read, one cycle latency.
  always @(posedge clk50) bus.mem_dout <= mem[bus.mem_addr];

  // Observe everything mid-cycle, away from the active edge.
  always @(negedge clk50) begin
    cyc++;
    pop_seen = bus.q_pop_front;
    if (bus.q_pop_front) pop_cyc.push_back(cyc);
    if (frame_done) fd_cyc.push_back(cyc);
    if (bus.pix_valid) valid_cycles++;
    if (bus.pix_valid && bus.pix_ready) got.push_back({bus.pix_x, bus.pix_y, bus.pix_rgb});
    if (bus.q_pop_front || busy) act_cycles++;
    if (busy && busy_prev && (addr_log.size() == 0 || addr_log[$] != int'(bus.mem_addr)))
      addr_log.push_back(int'(bus.mem_addr));
    busy_prev = busy;
  end

  // Show-ahead queue model: head visible while non-empty, removed on a pop strobe.
  initial begin
    bus.q_empty = 1'b1;
    bus.q_dout  = '0;
    forever begin
      @(posedge clk50);
      if (pop_seen && cmdq.size() > 0) cmdq.delete(0);
      #1;
      bus.q_empty = (cmdq.size() == 0);
      bus.q_dout  = (cmdq.size() > 0) ? cmdq[0] : 48'h0;
    end
  end

  function automatic logic [47:0] mk(input int x0, input int y0, input int base,
                                     input int w, input int h, input bit eof);
    logic [47:0] c;
    c = {10'(x0), 10'(y0), 9'(base), 4'(w - 1), 4'(h - 1), eof, 10'h0};
    return c;
  endfunction

  // Reference: raster order, row-major image at base (mod 512), drop off-screen
  // and magenta pixels.
  task automatic model_cmd(input logic [47:0] c);
    int x0, y0, base, w, h, x, y, a;
    x0 = int'(c[47:38]); y0 = int'(c[37:28]); base = int'(c[27:19]);
    w = int'(c[18:15]) + 1; h = int'(c[14:11]) + 1;
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++) begin
        x = x0 + k; y = y0 + r; a = (base + r * w + k) % 512;
        if (x < 640 && y < 480 && mem[a] != 24'hFF00FF)
          exp_px.push_back({10'(x), 10'(y), mem[a]});
      end
  endtask

  task automatic wait_idle(input int budget, input string tag, input bit rnd);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(posedge clk50); #1;
      if (rnd) bus.pix_ready = 1'($urandom_range(0, 1));
      n++;
      if (cmdq.size() == 0 && !busy && !bus.q_pop_front) quiet++; else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, budget);
    end
  endtask

  task automatic test_reset();
    int n;
    int g0;
    int v0;
    repeat (3) @(posedge clk50); #1;
    checks++;
    if ({bus.q_pop_front, bus.pix_valid, frame_done, busy, bus.mem_addr, bus.pix_x, bus.pix_y, bus.pix_rgb} !== '0) begin
      errors++;
      $display("FAIL reset_init: outputs %h, expected 0",
               {bus.q_pop_front, bus.pix_valid, frame_done, busy, bus.mem_addr, bus.pix_x, bus.pix_y, bus.pix_rgb});
    end
    @(posedge clk50); #2;
    reset_reg = 1'b0;
    enable = 1'b1;
    bus.pix_ready = 1'b0;
    mem[30] = 24'hABCDEF;
    g0 = got.size();
    cmdq.push_back(mk(77, 88, 30, 1, 1, 1'b1));
    n = 0;
    while (!bus.pix_valid && n < 50) begin @(posedge clk50); #1; n++; end
    checks++;
    if (bus.pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_reach_emit: pix_valid %b, expected 1", bus.pix_valid);
    end
    #5 reset_reg = 1'b1;
    #1;
    checks++;
    if ({bus.q_pop_front, bus.pix_valid, frame_done, busy, bus.mem_addr, bus.pix_x, bus.pix_y, bus.pix_rgb} !== '0) begin
      errors++;
      $display("FAIL reset_mid_emit: outputs %h, expected 0",
               {bus.q_pop_front, bus.pix_valid, frame_done, busy, bus.mem_addr, bus.pix_x, bus.pix_y, bus.pix_rgb});
    end
    repeat (2) @(posedge clk50); #2;
    reset_reg = 1'b0;
    v0 = valid_cycles;
    repeat (20) @(posedge clk50); #1;
    checks++;
    if (valid_cycles - v0 != 0 || got.size() != g0) begin
      errors++;
      $display("FAIL reset_after_release: valid cycles %0d pixels %0d, expected 0 and 0",
               valid_cycles - v0, got.size() - g0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy %b, expected 0", busy); end
    bus.pix_ready = 1'b1;
  endtask

  task automatic test_single();
    int g0, a0, p0;
    logic [43:0] e [4];
    mem[5] = 24'd1; mem[6] = 24'd2; mem[7] = 24'd3; mem[8] = 24'd4;
    e[0] = {10'd10, 10'd20, 24'd1}; e[1] = {10'd11, 10'd20, 24'd2};
    e[2] = {10'd10, 10'd21, 24'd3}; e[3] = {10'd11, 10'd21, 24'd4};
    g0 = got.size(); a0 = act_cycles; p0 = pop_cyc.size();
    cmdq.push_back(mk(10, 20, 5, 2, 2, 1'b0));
    wait_idle(200, "single", 1'b0);
    checks++;
    if (got.size() - g0 != 4) begin errors++; $display("FAIL single_count: got %0d pixels, expected 4", got.size() - g0); end
    for (int i = 0; i < 4 && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0 + i] !== e[i]) begin
        errors++;
        $display("FAIL single_px%0d: got %h, expected %h", i, got[g0 + i], e[i]);
      end
    end
    checks++;
    if (pop_cyc.size() - p0 != 1) begin errors++; $display("FAIL single_pops: got %0d, expected 1", pop_cyc.size() - p0); end
    // pop cycle + POP + 4 pixels x 4 cycles
    checks++;
    if (act_cycles - a0 != 18) begin errors++; $display("FAIL single_busy_len: got %0d cycles, expected 18", act_cycles - a0); end
  endtask

  task automatic test_transp_clip();
    int g0;
    mem[20] = 24'h00AA11; mem[21] = 24'hFF00FF; mem[22] = 24'h00BB22;
    g0 = got.size();
    cmdq.push_back(mk(638, 100, 20, 3, 1, 1'b0));
    wait_idle(200, "transp", 1'b0);
    checks++;
    if (got.size() - g0 != 1) begin errors++; $display("FAIL transp_count: got %0d pixels, expected 1", got.size() - g0); end
    checks++;
    if (got.size() > g0 && got[g0] !== {10'd638, 10'd100, 24'h00AA11}) begin
      errors++;
      $display("FAIL transp_px: got %h, expected %h", got[g0], {10'd638, 10'd100, 24'h00AA11});
    end
  endtask

  task automatic test_wrap();
    int g0, l0;
    int ea [4];
    ea[0] = 510; ea[1] = 511; ea[2] = 0; ea[3] = 1;
    mem[510] = 24'h000510; mem[511] = 24'h000511; mem[0] = 24'h000A00; mem[1] = 24'h000A01;
    g0 = got.size(); l0 = addr_log.size();
    cmdq.push_back(mk(50, 60, 510, 4, 1, 1'b0));
    wait_idle(200, "wrap", 1'b0);
    checks++;
    if (addr_log.size() - l0 != 4) begin errors++; $display("FAIL wrap_addr_count: got %0d addresses, expected 4", addr_log.size() - l0); end
    for (int i = 0; i < 4 && l0 + i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[l0 + i] != ea[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d: got %0d, expected %0d", i, addr_log[l0 + i], ea[i]);
      end
    end
    checks++;
    if (got.size() - g0 != 4 || got[got.size() - 1] !== {10'd53, 10'd60, 24'h000A01}) begin
      errors++;
      $display("FAIL wrap_pixels: got %0d pixels last %h, expected 4 last %h",
               got.size() - g0, got[got.size() - 1], {10'd53, 10'd60, 24'h000A01});
    end
  endtask

  task automatic test_backpressure();
    int g0, n;
    logic [43:0] e;
    e = {10'd300, 10'd200, 24'h123456};
    mem[40] = 24'h123456;
    bus.pix_ready = 1'b0;
    g0 = got.size();
    cmdq.push_back(mk(300, 200, 40, 1, 1, 1'b0));
    n = 0;
    while (!bus.pix_valid && n < 50) begin @(posedge clk50); #1; n++; end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk50);
      checks++;
      if ({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb} !== {1'b1, e}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h, expected %h", i, {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb}, {1'b1, e});
      end
    end
    @(posedge clk50); #1;
    bus.pix_ready = 1'b1;
    wait_idle(100, "bp", 1'b0);
    checks++;
    if (got.size() - g0 != 1) begin errors++; $display("FAIL bp_count: got %0d pixels, expected 1", got.size() - g0); end
    checks++;
    if (got.size() > g0 && got[g0] !== e) begin errors++; $display("FAIL bp_px: got %h, expected %h", got[g0], e); end
  endtask

  task automatic test_eof_enable();
    int g0, p0, f0, n;
    mem[60] = 24'h111111; mem[61] = 24'h222222;
    for (int i = 100; i < 105; i++) mem[i] = 24'h300000 + 24'(i);
    g0 = got.size(); p0 = pop_cyc.size(); f0 = fd_cyc.size();
    cmdq.push_back(mk(5, 5, 60, 1, 1, 1'b1));
    cmdq.push_back(mk(6, 6, 61, 1, 1, 1'b0));
    wait_idle(100, "eof", 1'b0);
    checks++;
    if (fd_cyc.size() - f0 != 1) begin errors++; $display("FAIL eof_pulses: got %0d, expected 1", fd_cyc.size() - f0); end
    checks++;
    if (pop_cyc.size() - p0 != 2) begin errors++; $display("FAIL eof_pops: got %0d, expected 2", pop_cyc.size() - p0); end
    if (fd_cyc.size() - f0 == 1 && pop_cyc.size() - p0 == 2) begin
      checks++;
      if (fd_cyc[f0] != pop_cyc[p0] + 6) begin
        errors++;
        $display("FAIL eof_fd_time: pulse at %0d, expected %0d", fd_cyc[f0], pop_cyc[p0] + 6);
      end
      checks++;
      if (pop_cyc[p0 + 1] != fd_cyc[f0] + 1) begin
        errors++;
        $display("FAIL eof_second_pop: pop at %0d, expected %0d", pop_cyc[p0 + 1], fd_cyc[f0] + 1);
      end
    end
    checks++;
    if (got.size() - g0 != 2 || got[got.size() - 1] !== {10'd6, 10'd6, 24'h222222}) begin
      errors++;
      $display("FAIL eof_pixels: got %0d pixels last %h, expected 2 last %h",
               got.size() - g0, got[got.size() - 1], {10'd6, 10'd6, 24'h222222});
    end
    // enable dropped while a 2x2 sprite is in flight
    g0 = got.size(); p0 = pop_cyc.size();
    cmdq.push_back(mk(0, 0, 100, 2, 2, 1'b0));
    cmdq.push_back(mk(1, 1, 104, 1, 1, 1'b0));
    n = 0;
    while (pop_cyc.size() == p0 && n < 20) begin @(posedge clk50); #1; n++; end
    @(posedge clk50); #1;
    enable = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(posedge clk50); #1; n++; end
    repeat (20) @(posedge clk50); #1;
    checks++;
    if (got.size() - g0 != 4) begin errors++; $display("FAIL en_complete: got %0d pixels, expected 4", got.size() - g0); end
    checks++;
    if (pop_cyc.size() - p0 != 1 || busy !== 1'b0 || cmdq.size() != 1) begin
      errors++;
      $display("FAIL en_hold: pops %0d busy %b queued %0d, expected 1 0 1", pop_cyc.size() - p0, busy, cmdq.size());
    end
    enable = 1'b1;
    wait_idle(100, "en_resume", 1'b0);
    checks++;
    if (got.size() - g0 != 5) begin errors++; $display("FAIL en_resume_count: got %0d pixels, expected 5", got.size() - g0); end
  endtask

  task automatic test_random();
    int g0, f0, efd, sel, x0, y0;
    logic [47:0] c;
    for (int i = 0; i < 512; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 24'hFF00FF : 24'($urandom);
    exp_px.delete();
    efd = 0;
    g0 = got.size(); f0 = fd_cyc.size();
    for (int n = 0; n < 12; n++) begin
      sel = $urandom_range(0, 2);
      x0 = (sel == 0) ? $urandom_range(0, 623) : (sel == 1) ? $urandom_range(625, 639) : $urandom_range(640, 1023);
      sel = $urandom_range(0, 2);
      y0 = (sel == 0) ? $urandom_range(0, 463) : (sel == 1) ? $urandom_range(465, 479) : $urandom_range(480, 1023);
      c = mk(x0, y0, $urandom_range(0, 511), $urandom_range(1, 16), $urandom_range(1, 16), 1'($urandom_range(0, 1)));
      c[9:0] = 10'($urandom);
      model_cmd(c);
      if (c[10]) efd++;
      cmdq.push_back(c);
    end
    wait_idle(40000, "random", 1'b1);
    bus.pix_ready = 1'b1;
    checks++;
    if (got.size() - g0 != exp_px.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d pixels, expected %0d", got.size() - g0, exp_px.size());
    end
    for (int i = 0; i < exp_px.size() && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0 + i] !== exp_px[i]) begin
        errors++;
        $display("FAIL rand_px%0d: got %h, expected %h", i, got[g0 + i], exp_px[i]);
      end
    end
    checks++;
    if (fd_cyc.size() - f0 != efd) begin
      errors++;
      $display("FAIL rand_frame_done: got %0d pulses, expected %0d", fd_cyc.size() - f0, efd);
    end
  endtask

  initial begin
    reset_reg = 1'b1;
    enable = 1'b0;
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 24'h0;
    test_reset();
    test_single();
    test_transp_clip();
    test_wrap();
    test_backpressure();
    test_eof_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
